pipelined_adder: RTL and testbench

PIPELINED_ADDER -- requirements
Module: pipelined_adder

---
 rtl/pipelined_adder_if.sv | 26 ++
 rtl/pipelined_adder.sv | 76 +++++++
 tb/tb_pipelined_adder.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_adder_if.sv
// rtl/pipelined_adder_if.sv - operand/result handshake bundle for pipelined_adder
interface pipelined_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             Ovf;

  modport master (
    output in_valid, A, B, Cin, sub, out_ready,
    input  in_ready, out_valid, S, Cout, Ovf
  );

  modport slave (
    input  in_valid, A, B, Cin, sub, out_ready,
    output in_ready, out_valid, S, Cout, Ovf
  );
endinterface

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - CHUNK-bit-per-stage ripple adder/subtractor with valid/ready flow control
// Level 0 holds the captured operands; stage k adds chunk k and writes level k+1.
module pipelined_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic             clk,
  input logic             reset,
  pipelined_adder_if.slave bus
);
  localparam int STAGES = WIDTH / CHUNK;

  logic             r_v [0:STAGES];
  logic             r_c [0:STAGES];
  logic [WIDTH-1:0] r_s [0:STAGES];
  logic [WIDTH-1:0] r_a [0:STAGES-1];
  logic [WIDTH-1:0] r_b [0:STAGES-1];
  logic             r_o;

  logic [WIDTH-1:0] w_s [0:STAGES-1];
  logic             w_c [0:STAGES-1];
  logic             w_adv;
  logic             w_ovf;

  assign w_adv        = ~r_v[STAGES] | bus.out_ready;
  assign bus.in_ready = w_adv;

  // Result chunks above k are still zero at level k, so each stage ORs its chunk in.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK:0] w_sum;
    assign w_sum  = {1'b0, r_a[k][k*CHUNK +: CHUNK]} + {1'b0, r_b[k][k*CHUNK +: CHUNK]}
                  + {{CHUNK{1'b0}}, r_c[k]};
    assign w_s[k] = r_s[k] | (WIDTH'(w_sum[CHUNK-1:0]) << (k*CHUNK));
    assign w_c[k] = w_sum[CHUNK];
  end

  assign w_ovf = (r_a[STAGES-1][WIDTH-1] == r_b[STAGES-1][WIDTH-1])
               & (w_s[STAGES-1][WIDTH-1] != r_a[STAGES-1][WIDTH-1]);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k <= STAGES; k++) begin
        r_v[k] <= 1'b0;
        r_c[k] <= 1'b0;
        r_s[k] <= '0;
      end
      for (int k = 0; k < STAGES; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
      end
      r_o <= 1'b0;
    end else if (w_adv) begin
      r_v[0] <= bus.in_valid;
      if (bus.in_valid) begin
        r_a[0] <= bus.A;
        r_b[0] <= bus.sub ? ~bus.B : bus.B;
        r_c[0] <= bus.sub | bus.Cin;
      end
      for (int k = 0; k < STAGES; k++) begin
        r_v[k+1] <= r_v[k];
        r_c[k+1] <= w_c[k];
        r_s[k+1] <= w_s[k];
      end
      for (int k = 0; k < STAGES - 1; k++) begin
        r_a[k+1] <= r_a[k];
        r_b[k+1] <= r_b[k];
      end
      r_o <= w_ovf;
    end
  end

  assign bus.out_valid = r_v[STAGES];
  assign bus.S         = r_s[STAGES];
  assign bus.Cout      = r_c[STAGES];
  assign bus.Ovf       = r_o;
endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - self-checking bench for pipelined_adder (WIDTH=16, CHUNK=4)
module tb_pipelined_adder;
  localparam int WIDTH = 16;
  localparam int CHUNK = 4;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        o;
  } res_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipelined_adder_if #(.WIDTH(WIDTH)) bus ();
  pipelined_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (.clk(clk), .reset(reset), .bus(bus));

  res_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   npops = 0;
  logic prev_stall = 1'b0;
  res_t prev_out;
  res_t last_out;
  logic popped;
  logic accepted;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain unsigned/signed integer arithmetic on the operands.
  function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sb);
    res_t r;
    int unsigned ua, ub, ur;
    int sa, sbv, sr;
    ua  = 32'(a);
    ub  = 32'(b);
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    if (sb) begin
      ur  = ua - ub;
      sr  = sa - sbv;
      r.c = (ua >= ub);
    end else begin
      ur  = ua + ub + 32'(cin);
      sr  = sa + sbv + int'(cin);
      r.c = (ur > 32'h0000_FFFF);
    end
    r.s = ur[15:0];
    r.o = (sr > 32767) || (sr < -32768);
    return r;
  endfunction

  task automatic cycle();
    res_t cur;
    res_t exp;
    @(negedge clk);
    popped   = 1'b0;
    accepted = 1'b0;
    cur = {bus.S, bus.Cout, bus.Ovf};
    if (!reset) begin
      chk("in_ready", 32'(bus.in_ready), 32'(!bus.out_valid || bus.out_ready));
      if (prev_stall) begin
        chk("stall_valid", 32'(bus.out_valid), 32'd1);
        chk("stall_hold", 32'(cur), 32'(prev_out));
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("result_pending", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          exp = q.pop_front();
          chk("S", 32'(cur.s), 32'(exp.s));
          chk("Cout", 32'(cur.c), 32'(exp.c));
          chk("Ovf", 32'(cur.o), 32'(exp.o));
        end
        npops++;
        popped   = 1'b1;
        last_out = cur;
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(model(bus.A, bus.B, bus.Cin, bus.sub));
        accepted = 1'b1;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_out   = cur;
    end else begin
      prev_stall = 1'b0;
    end
    @(posedge clk);
    if (reset) q.delete();
    #1;
  endtask

  task automatic directed_one(input logic [15:0] a, input logic [15:0] b, input logic cin,
                              input logic sb, input logic [15:0] es, input logic ec,
                              input logic eo, input string tag);
    int   edges;
    logic seen;
    bus.A = a; bus.B = b; bus.Cin = cin; bus.sub = sb;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    cycle();
    chk({tag, "_accept"}, 32'(accepted), 32'd1);
    bus.in_valid = 1'b0;
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 20) begin
      cycle();
      if (popped) seen = 1'b1;
      else edges++;
    end
    chk({tag, "_latency"}, 32'(edges), 32'd4);
    chk({tag, "_S"}, 32'(last_out.s), 32'(es));
    chk({tag, "_Cout"}, 32'(last_out.c), 32'(ec));
    chk({tag, "_Ovf"}, 32'(last_out.o), 32'(eo));
  endtask

  initial begin
    int base;
    int i;
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.A = '0; bus.B = '0; bus.Cin = 1'b0; bus.sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_S", 32'(bus.S), 32'd0);
    chk("rst_Cout", 32'(bus.Cout), 32'd0);
    chk("rst_Ovf", 32'(bus.Ovf), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    directed_one(16'h00B5, 16'h00A7, 1'b0, 1'b0, 16'h015C, 1'b0, 1'b0, "add_basic");
    directed_one(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "add_wrap");
    directed_one(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf");
    directed_one(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow");
    directed_one(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");
    directed_one(16'h1234, 16'h0FF0, 1'b1, 1'b0, 16'h2225, 1'b0, 1'b0, "add_cin");

    // Back-to-back sets against a 1,0,0,1 out_ready pattern.
    base = npops;
    i = 0;
    for (int cyc = 0; cyc < 200 && (npops - base) < 8; cyc++) begin
      bus.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      bus.in_valid  = (i < 8);
      bus.A = 16'(i); bus.B = 16'h0100; bus.Cin = 1'b0; bus.sub = 1'b0;
      cycle();
      if (accepted) i++;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (8) cycle();
    chk("b2b_count", 32'(npops - base), 32'd8);
    chk("b2b_drained", 32'(q.size()), 32'd0);

    // Reset while three sets are in flight, with a simultaneous capture attempt.
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1; bus.A = 16'(16'h0010 + k); bus.B = 16'h0020;
      cycle();
    end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("rst2_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst2_S", 32'(bus.S), 32'd0);
    @(posedge clk);
    #1;
    base = npops;
    repeat (8) cycle();
    chk("rst2_no_output", 32'(npops - base), 32'd0);
    directed_one(16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, "post_rst");

    // Random traffic with random back-pressure.
    for (int cyc = 0; cyc < 400; cyc++) begin
      bus.in_valid  = 1'($urandom_range(0, 3) != 0);
      bus.out_ready = 1'($urandom_range(0, 2) != 0);
      bus.A   = 16'($urandom);
      bus.B   = 16'($urandom);
      bus.Cin = 1'($urandom);
      bus.sub = 1'($urandom);
      cycle();
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 50 && q.size() != 0; cyc++) cycle();
    repeat (6) cycle();
    chk("rand_drained", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
